// File: rtl/prog_loader_pkg.sv
// Shared state encoding and constants for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/prog_loader_cnt.sv
// Loadable up-counter with a terminal-match flag (count equals terminal).
module prog_loader_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         match
);

    // Counter register: load wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    // Terminal compare.
    always_comb begin
        match = (count == terminal);
    end

endmodule

// File: rtl/prog_loader.sv
// Run-control front end: loads instruction words, releases the core, halts it after N cycles.
// Optional checksum output enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic [ADDR_W-1:0] core_pc_init,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_e             state_r;
    logic [ADDR_W-1:0]  base_pc_r;
    logic [CNT_W-1:0]   num_words_r;
    logic [CNT_W-1:0]   run_cycles_r;

    logic               start_ok_s;
    logic               accept_s;
    logic               run_inc_s;
    logic [CNT_W-1:0]   word_idx_s;
    logic [CNT_W-1:0]   word_term_s;
    logic [CNT_W-1:0]   cyc_term_s;
    logic               word_last_s;
    logic               cyc_last_s;
    logic [ADDR_W-1:0]  word_addr_s;

    // Handshake, start qualification and terminal values.
    always_comb begin
        in_ready    = (state_r == ST_LOAD);
        accept_s    = in_valid && (state_r == ST_LOAD);
        run_inc_s   = (state_r == ST_RUN);
        start_ok_s  = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        // Terminals are one below the limits; the zero cases never reach these states.
        word_term_s = num_words_r - {{(CNT_W-1){1'b0}}, 1'b1};
        cyc_term_s  = run_cycles_r - {{(CNT_W-1){1'b0}}, 1'b1};
        word_addr_s = base_pc_r + (ADDR_W'(word_idx_s) << WORD_SHIFT);
    end

    prog_loader_cnt #(.W(CNT_W)) u_word_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok_s),
        .load_val ({CNT_W{1'b0}}),
        .inc      (accept_s),
        .terminal (word_term_s),
        .count    (word_idx_s),
        .match    (word_last_s)
    );

    prog_loader_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok_s),
        .load_val ({CNT_W{1'b0}}),
        .inc      (run_inc_s),
        .terminal (cyc_term_s),
        .count    (cycle_count),
        .match    (cyc_last_s)
    );

    // Sequencer FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            base_pc_r    <= {ADDR_W{1'b0}};
            num_words_r  <= {CNT_W{1'b0}};
            run_cycles_r <= {CNT_W{1'b0}};
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= {DATA_W{1'b0}};
            core_rst     <= 1'b1;
            core_pc_init <= {ADDR_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        base_pc_r    <= base_pc;
                        num_words_r  <= num_words;
                        run_cycles_r <= run_cycles;
                        core_pc_init <= base_pc;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        if (num_words == {CNT_W{1'b0}}) begin
                            state_r <= ST_RELEASE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_addr_s;
                        imem_wdata <= in_data;
                        if (word_last_s) begin
                            state_r <= ST_RELEASE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RELEASE: begin
                    // The last write is landing this cycle while the core is still held.
                    if (run_cycles_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_r  <= ST_RUN;
                        core_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cyc_last_s) begin
                        state_r  <= ST_DONE;
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Modulo-2^DATA_W sum of every word accepted during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= {DATA_W{1'b0}};
        end else if (start_ok_s) begin
            checksum <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            checksum <= checksum + in_data;
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized load/run sequences against a reference model.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_pc;
    logic [15:0] num_words;
    logic [15:0] run_cycles;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic [31:0] core_pc_init;
    logic        busy;
    logic        done;
    logic [15:0] cycle_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_pc      (base_pc),
        .num_words    (num_words),
        .run_cycles   (run_cycles),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .core_pc_init (core_pc_init),
        .busy         (busy),
        .done         (done),
        .cycle_count  (cycle_count)
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t         wq[$];
    int          low_cnt = 0;
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [31:0] wbuf[16];
    bit          vpat[16];
    int          vpat_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe memory writes and cycles the core spends out of reset.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back('{imem_addr, imem_wdata, cyc});
        if (core_rst === 1'b0) low_cnt <= low_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [31:0] base, input int n, input int nrun);
        base_pc    = base;
        num_words  = 16'(n);
        run_cycles = 16'(nrun);
        start      = 1'b1;
        step();
        start      = 1'b0;
        base_pc    = $urandom;
        num_words  = 16'($urandom);
        run_cycles = 16'($urandom);
    endtask

    // Full load/run sequence checked against the expected write list, run length and final state.
    task automatic do_sequence(input logic [31:0] base, input int n, input int nrun, input int stall_pct);
        int          w0, l0, idx, k, stp;
        logic        rdy, v;
        logic [31:0] exp_a;
        logic [31:0] sum;
        w0  = wq.size();
        l0  = low_cnt;
        sum = 32'd0;
        start_seq(base, n, nrun);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL seq_busy got %b exp 1", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL seq_done_clear got %b exp 0", done); else pass_cnt++;
        chk_cnt++; if (core_pc_init !== base) $display("FAIL pc_init got %h exp %h", core_pc_init, base); else pass_cnt++;
        idx = 0; k = 0; stp = 0;
        while (idx < n && k < 500) begin
            if (vpat_len > 0) v = (stp < vpat_len) ? vpat[stp] : 1'b1;
            else v = ($urandom_range(0, 99) >= stall_pct);
            in_valid = v;
            in_data  = wbuf[idx];
            rdy      = in_ready;
            step();
            if (v && rdy) begin
                sum = sum + wbuf[idx];
                idx++;
            end
            k++; stp++;
        end
        if (n > 0) begin
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL ready_drop got %b exp 0", in_ready); else pass_cnt++;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_cnt++; if (checksum !== sum) $display("FAIL checksum got %h exp %h", checksum, sum); else pass_cnt++;
`endif
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        k = 0;
        while (done !== 1'b1 && k < 500) begin
            step();
            k++;
        end
        in_valid = 1'b0;
        chk_cnt++; if (done !== 1'b1) $display("FAIL done_timeout got %b exp 1", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL end_busy got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (core_rst !== 1'b1) $display("FAIL end_core_rst got %b exp 1", core_rst); else pass_cnt++;
        chk_cnt++; if (cycle_count !== 16'(nrun)) $display("FAIL cycle_count got %0d exp %0d", cycle_count, nrun); else pass_cnt++;
        chk_cnt++; if (low_cnt - l0 != nrun) $display("FAIL run_len got %0d exp %0d", low_cnt - l0, nrun); else pass_cnt++;
        chk_cnt++; if (wq.size() - w0 != n) $display("FAIL write_cnt got %0d exp %0d", wq.size() - w0, n); else pass_cnt++;
        for (int i = 0; i < n && (w0 + i) < wq.size(); i++) begin
            exp_a = base + 32'(i * 4);
            chk_cnt++; if (wq[w0+i].a !== exp_a) $display("FAIL wr_addr[%0d] got %h exp %h", i, wq[w0+i].a, exp_a); else pass_cnt++;
            chk_cnt++; if (wq[w0+i].d !== wbuf[i]) $display("FAIL wr_data[%0d] got %h exp %h", i, wq[w0+i].d, wbuf[i]); else pass_cnt++;
        end
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk_cnt++; if ({core_rst, in_ready, imem_we, busy, done} !== 5'b10000)
            $display("FAIL %s_ctrl got %b exp 10000", tag, {core_rst, in_ready, imem_we, busy, done}); else pass_cnt++;
        chk_cnt++; if (imem_addr !== 32'd0) $display("FAIL %s_addr got %h exp 0", tag, imem_addr); else pass_cnt++;
        chk_cnt++; if (imem_wdata !== 32'd0) $display("FAIL %s_wdata got %h exp 0", tag, imem_wdata); else pass_cnt++;
        chk_cnt++; if (core_pc_init !== 32'd0) $display("FAIL %s_pc_init got %h exp 0", tag, core_pc_init); else pass_cnt++;
        chk_cnt++; if (cycle_count !== 16'd0) $display("FAIL %s_cycles got %0d exp 0", tag, cycle_count); else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) step();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) step();
        chk_cnt++; if ({core_rst, busy, in_ready} !== 3'b100) $display("FAIL idle_hold got %b exp 100", {core_rst, busy, in_ready}); else pass_cnt++;
    endtask

    task automatic test_basic_load();
        wbuf[0] = 32'h2231_000A;
        wbuf[1] = 32'h2232_0014;
        do_sequence(32'd900, 2, 9, 0);
    endtask

    task automatic test_stalls();
        int w0;
        vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat[4] = 1'b1;
        vpat_len = 5;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        w0 = wq.size();
        do_sequence(32'd0, 3, 2, 0);
        vpat_len = 0;
        if (wq.size() >= w0 + 3) begin
            chk_cnt++; if (wq[w0+1].c - wq[w0].c != 3) $display("FAIL stall_gap1 got %0d exp 3", wq[w0+1].c - wq[w0].c); else pass_cnt++;
            chk_cnt++; if (wq[w0+2].c - wq[w0].c != 4) $display("FAIL stall_gap2 got %0d exp 4", wq[w0+2].c - wq[w0].c); else pass_cnt++;
        end else begin
            chk_cnt++; $display("FAIL stall_writes got %0d exp 3", wq.size() - w0);
        end
    endtask

    task automatic test_zero_length();
        int l0;
        do_sequence(32'h0000_0200, 0, 5, 0);
        l0 = low_cnt;
        start_seq(32'h0000_0300, 0, 0);
        chk_cnt++; if (done !== 1'b0) $display("FAIL zr_release_done got %b exp 0", done); else pass_cnt++;
        step();
        chk_cnt++; if (done !== 1'b1) $display("FAIL zr_done got %b exp 1", done); else pass_cnt++;
        chk_cnt++; if (low_cnt != l0) $display("FAIL zr_core_rst_low got %0d exp 0", low_cnt - l0); else pass_cnt++;
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        do_sequence(32'h0000_0300, 2, 0, 30);
    endtask

    task automatic test_ignored_start();
        int w0, l0, k;
        wbuf[0] = $urandom;
        w0 = wq.size();
        l0 = low_cnt;
        start_seq(32'd100, 1, 20);
        in_valid = 1'b1;
        in_data  = wbuf[0];
        step();
        in_valid = 1'b0;
        k = 0;
        while (core_rst !== 1'b0 && k < 20) begin step(); k++; end
        repeat (5) step();
        start_seq(32'h0000_1234, 3, 2);
        k = 0;
        while (done !== 1'b1 && k < 100) begin step(); k++; end
        chk_cnt++; if (cycle_count !== 16'd20) $display("FAIL ign_cycles got %0d exp 20", cycle_count); else pass_cnt++;
        chk_cnt++; if (low_cnt - l0 != 20) $display("FAIL ign_run_len got %0d exp 20", low_cnt - l0); else pass_cnt++;
        chk_cnt++; if (core_pc_init !== 32'd100) $display("FAIL ign_pc_init got %h exp 64", core_pc_init); else pass_cnt++;
        chk_cnt++; if (wq.size() - w0 != 1) $display("FAIL ign_writes got %0d exp 1", wq.size() - w0); else pass_cnt++;
        // Restart straight from DONE.
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        do_sequence(32'h0000_0A00, 2, 4, 30);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        start_seq(32'h0000_0040, 4, 3);
        in_valid = 1'b1;
        in_data  = wbuf[0];
        step();
        in_valid = 1'b0;
        chk_cnt++; if (imem_we !== 1'b1 || imem_addr !== 32'h40) $display("FAIL mid_first_write got %b/%h exp 1/00000040", imem_we, imem_addr); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        step();
        rst = 1'b0;
        step();
        do_sequence(32'h0000_0040, 4, 3, 25);
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int k;
        start_seq(32'h0000_0080, 2, 1);
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; step();
        in_data = 32'h0000_0002; step();
        in_valid = 1'b0;
        chk_cnt++; if (checksum !== 32'h0000_0001) $display("FAIL cks_release got %h exp 00000001", checksum); else pass_cnt++;
        k = 0;
        while (done !== 1'b1 && k < 20) begin step(); k++; end
        chk_cnt++; if (checksum !== 32'h0000_0001) $display("FAIL cks_done got %h exp 00000001", checksum); else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] base;
        int n, nrun;
        for (int it = 0; it < 8; it++) begin
            base = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            n    = (it == 0) ? 4 : $urandom_range(0, 6);
            nrun = $urandom_range(0, 12);
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            do_sequence(base, n, nrun, $urandom_range(0, 60));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_pc    = 32'd0;
        num_words  = 16'd0;
        run_cycles = 16'd0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        test_reset();
        test_basic_load();
        test_stalls();
        test_zero_length();
        test_ignored_start();
        test_reset_mid_load();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
